// File: rtl/bank_word_sequencer.sv
// Word-select sequencer sharing the bank word decoder between a single-access host (A) and a
// burst sweep engine (B). Optional abort input enabled by `define BANK_WORD_SEQ_ABORT_EN.
module bank_word_sequencer #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DWELL  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              done_a,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] burst_first,
    input  logic [ADDR_W-1:0] burst_last,
`ifdef BANK_WORD_SEQ_ABORT_EN
    input  logic              burst_abort,
`endif
    output logic              burst_busy,
    output logic              burst_done,
    output logic [ADDR_W-1:0] word_sel,
    output logic              word_en
);

    // StPause serves an A access while a burst is suspended or latched and waiting.
    typedef enum logic [1:0] {StIdle, StSingle, StBurst, StPause} state_e;

    localparam logic [3:0] CntLast = 4'(DWELL - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              arm_q, arm_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              abort_hit;
    logic              dwell_end, end_word, a_acc, b_acc;
    logic [ADDR_W-1:0] nxt;

`ifdef BANK_WORD_SEQ_ABORT_EN
    logic abort_q, abort_d;
    assign abort_hit = abort_q || burst_abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign dwell_end = (cnt_q == CntLast);
    assign end_word  = (cur_q == last_q) || abort_hit;
    assign nxt       = cur_q + ADDR_W'(1);
    assign a_acc     = req_a && arm_q && (state_q == StIdle || (state_q == StBurst && dwell_end));
    assign b_acc     = burst_start && !busy_q && (state_q == StIdle || state_q == StSingle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arm_d   = arm_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        last_d  = last_q;
        busy_d  = busy_q;
`ifdef BANK_WORD_SEQ_ABORT_EN
        abort_d = abort_q;
        if (burst_abort && busy_q && (state_q == StBurst || state_q == StPause)) abort_d = 1'b1;
`endif

        if (!req_a) arm_d = 1'b1;
        else if (a_acc) arm_d = 1'b0;

        // busy stays high for one cycle after burst_done, then falls
        if (done_q) busy_d = 1'b0;
        if (b_acc) begin
            cur_d  = burst_first;
            last_d = burst_last;
            busy_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (a_acc) begin
                    state_d = b_acc ? StPause : StSingle;
                    sel_d   = addr_a;
                end else if (b_acc) begin
                    state_d = StBurst;
                    sel_d   = burst_first;
                end
            end
            StSingle: begin
                cnt_d = cnt_q + 4'd1;
                if (dwell_end) begin
                    cnt_d = 4'd0;
                    if (b_acc) begin
                        state_d = StBurst;
                        sel_d   = burst_first;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (b_acc) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                cnt_d = cnt_q + 4'd1;
                if (dwell_end) begin
                    cnt_d   = 4'd0;
                    state_d = StBurst;
                    sel_d   = cur_q;
                end
            end
            StBurst: begin
                cnt_d = cnt_q + 4'd1;
                if (dwell_end) begin
                    cnt_d = 4'd0;
                    if (end_word) begin
`ifdef BANK_WORD_SEQ_ABORT_EN
                        abort_d = 1'b0;
`endif
                        state_d = a_acc ? StSingle : StIdle;
                        if (a_acc) sel_d = addr_a;
                    end else begin
                        cur_d   = nxt;
                        state_d = a_acc ? StPause : StBurst;
                        sel_d   = a_acc ? addr_a : nxt;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign burst_done = (state_q == StBurst) && dwell_end && end_word;
    assign done_d     = burst_done;
    assign done_a     = (state_q == StSingle || state_q == StPause) && dwell_end;
    assign word_en    = (state_q != StIdle);
    assign word_sel   = sel_q;
    assign burst_busy = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            arm_q   <= 1'b1;
            sel_q   <= '0;
            cur_q   <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BANK_WORD_SEQ_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BANK_WORD_SEQ_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

endmodule
